csa_accum_ctrl: RTL and testbench
=================================

Name: csa_accum_ctrl

Overview:
- Sequential multi-operand accumulator controller. It streams N-bit unsigned operands through a 3:2 carry-save compress step into redundant sum/carry registers, one operand per cycle.
- At packet end it resolves the redundant pair with a chunked, multi-cycle carry-propagate add and presents one result under a valid/ready handshake.
- Sits in front of result consumers that need the sum of a variable-length operand packet without a full-width adder in the accumulate loop.

Parameters:
- N, 8, operand width in bits.
- MAX_OPS, 4, maximum operands per packet (>=2); the packet is force-terminated when this is reached.
- CHUNK, 4, bits resolved per cycle in the final carry-propagate add (1..ACC_W).
- Derived (localparam), not overridable: ACC_W = N + clog2(MAX_OPS); CNT_W = clog2(MAX_OPS+1); NCHUNK = ceil(ACC_W/CHUNK).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand valid.
- in_ready  output  1  controller can accept an operand.
- in_data  input  N  operand, unsigned.
- in_last  input  1  marks the final operand of the packet.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  ACC_W  resolved packet sum.
- out_count  output  CNT_W  number of operands in the packet.

Behaviour:
- Reset: rst_n low at a rising edge forces state IDLE and clears sum_r, carry_r, count, chunk index, chunk carry and out_result to 0. After reset, out_valid=0, out_count=0 and in_ready=1. Reset mid-packet or mid-resolve aborts the packet silently; no partial result is emitted.
- Accept: an operand is accepted on an edge where in_valid && in_ready.
- in_ready = 1 in IDLE and ACCUM; 0 in RESOLVE and DONE. Input is never accepted while a result is pending.
- IDLE, on accept:
  - sum_r <= zero-extended in_data; carry_r <= 0; count <= 1.
  - Go to RESOLVE if in_last, else ACCUM.
- ACCUM, on accept, with x = zero-extended in_data:
  - sum_r <= sum_r ^ carry_r ^ x.
  - carry_r <= (majority(sum_r, carry_r, x) << 1) truncated to ACC_W.
  - count <= count + 1.
  - Go to RESOLVE if in_last or count+1 == MAX_OPS.
- ACCUM, no accept: hold all state. Gaps in in_valid are allowed indefinitely.
- RESOLVE: runs for exactly NCHUNK cycles, chunk index k = 0..NCHUNK-1, LSB chunk first.
  - Each cycle: out_result[chunk k] <= sum_r[k] + carry_r[k] + cc; cc <= carry-out of that chunk.
  - cc is cleared on entry to RESOLVE.
  - The last chunk may be narrower than CHUNK; its carry-out is discarded (it cannot be set given the ACC_W sizing).
  - Go to DONE after chunk NCHUNK-1.
- Latency: out_valid rises exactly NCHUNK+1 rising edges after the edge that accepts the final operand. That edge enters RESOLVE, NCHUNK edges resolve the chunks, and the next edge enters DONE.
- DONE:
  - out_valid=1; out_result and out_count are held stable until handshake.
  - On out_valid && out_ready: go to IDLE. out_valid drops on that edge; out_result and out_count retain their values.
- out_result must be bit-exact with the true sum of the packet operands; no overflow is possible by construction.
- When in_last coincides with count+1 == MAX_OPS, the packet terminates normally (in_last takes precedence for the optional flag).
- A single-operand packet (in_last on the first operand) still passes through RESOLVE with carry_r = 0.

Optional Feature:
- Macro: CSA_ACCUM_CTRL_FORCED_FLAG_EN.
- Defined: adds output port out_forced (1 bit), valid with out_valid.
  - out_forced = 1 iff the packet ended because count reached MAX_OPS without in_last on that operand.
  - Registered on the terminating accept; reset value 0.
- Undefined: port absent. Termination behaviour is identical either way.

Test Plan (N=8, MAX_OPS=4, CHUNK=4, so ACC_W=10, CNT_W=3, NCHUNK=3):
- Single operand 0xA5 with in_last -> out_valid high 4 edges after accept; out_result=165, out_count=1; in_ready=0 until the out handshake.
- 0xFF x4, in_last on the 4th -> out_result=1020 (0x3FC), out_count=4; exercises a full-width carry chain across all 3 chunks.
- 10,20,30,40,50 streamed with in_last never set -> forced end after 40; out_result=100, out_count=4, out_forced=1 (macro on). The 50 is held off by in_ready=0 until out_ready, then starts a new packet.
- Operands 1, gap, 2, 2-cycle gap, 3+in_last -> out_result=6, out_count=3; state held across the gaps.
- out_ready low for 5 cycles in DONE -> out_valid, out_result and out_count stable and in_ready=0 throughout; handshake returns to IDLE with in_ready=1 next cycle.
- rst_n low for one edge during the 2nd RESOLVE cycle of packet {0x80,0x80,last} -> IDLE, out_valid=0, out_result=0. The next packet {7,last} yields 7 with no residue.

Source files
------------

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: multi-operand accumulator. Each operand is folded into a
// redundant sum/carry pair with a 3:2 compressor. At packet end the pair is
// resolved CHUNK bits per cycle and the sum is offered on a valid/ready port.
// Optional feature macro: CSA_ACCUM_CTRL_FORCED_FLAG_EN adds out_forced,
// which flags packets closed by reaching MAX_OPS rather than by in_last.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload stable while valid is high and
// ready is low. Ready never depends on valid on the same port.
module csa_accum_ctrl #(
  parameter int N       = 8,
  parameter int MAX_OPS = 4,
  parameter int CHUNK   = 4,
  localparam int ACC_W  = N + $clog2(MAX_OPS),
  localparam int CNT_W  = $clog2(MAX_OPS + 1),
  localparam int NCHUNK = (ACC_W + CHUNK - 1) / CHUNK,
  localparam int IDX_W  = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_result,
  output logic [CNT_W-1:0] out_count
`ifdef CSA_ACCUM_CTRL_FORCED_FLAG_EN
  ,
  output logic             out_forced
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESOLVE, S_DONE} state_e;

  localparam logic [ACC_W-1:0] CHUNK_MASK = ACC_W'((1 << CHUNK) - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W-1:0] carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cc_q, cc_d;
  logic [ACC_W-1:0] result_q, result_d;

  logic [ACC_W-1:0] x_ext;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic [ACC_W-1:0] sum_sh, carry_sh, maj;
  logic [CHUNK:0]   csum;
  int               shamt;

  assign x_ext   = ACC_W'(in_data);
  assign cnt_inc = count_q + CNT_W'(1);
  assign accept  = in_valid && in_ready;

  assign in_ready   = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = result_q;
  assign out_count  = count_q;

  // Next-state logic: compress in ACCUM, one chunk per cycle in RESOLVE.
  // RESOLVE writes chunks while idx < NCHUNK and spends idx == NCHUNK
  // handing over to DONE, so out_valid rises NCHUNK+1 edges after the
  // final accept.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    count_d  = count_q;
    idx_d    = idx_q;
    cc_d     = cc_q;
    result_d = result_q;
    shamt    = int'(idx_q) * CHUNK;
    sum_sh   = sum_q >> shamt;
    carry_sh = carry_q >> shamt;
    csum     = {1'b0, sum_sh[CHUNK-1:0]} + {1'b0, carry_sh[CHUNK-1:0]}
             + {{CHUNK{1'b0}}, cc_q};
    maj      = (sum_q & carry_q) | (sum_q & x_ext) | (carry_q & x_ext);
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          sum_d   = x_ext;
          carry_d = '0;
          count_d = CNT_W'(1);
          idx_d   = '0;
          cc_d    = 1'b0;
          state_d = in_last ? S_RESOLVE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          sum_d   = sum_q ^ carry_q ^ x_ext;
          carry_d = maj << 1;
          count_d = cnt_inc;
          if (in_last || (cnt_inc == CNT_W'(MAX_OPS))) begin
            idx_d   = '0;
            cc_d    = 1'b0;
            state_d = S_RESOLVE;
          end
        end
      end
      S_RESOLVE: begin
        if (idx_q == IDX_W'(NCHUNK)) begin
          state_d = S_DONE;
        end else begin
          // Bits shifted past ACC_W drop out, which discards the top carry.
          result_d = (result_q & ~(CHUNK_MASK << shamt))
                   | (ACC_W'(csum[CHUNK-1:0]) << shamt);
          cc_d     = csum[CHUNK];
          idx_d    = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sum_q    <= '0;
      carry_q  <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      cc_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      cc_q     <= cc_d;
      result_q <= result_d;
    end
  end

`ifdef CSA_ACCUM_CTRL_FORCED_FLAG_EN
  logic forced_q, forced_d;

  // Record why a packet ended, on the accept that ends it.
  always_comb begin
    forced_d = forced_q;
    if (accept && (in_last || ((state_q == S_ACCUM) && (cnt_inc == CNT_W'(MAX_OPS)))))
      forced_d = !in_last;
  end

  // Termination-cause flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) forced_q <= 1'b0;
    else        forced_q <= forced_d;
  end

  assign out_forced = forced_q;
`endif

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Bench for csa_accum_ctrl: directed cases plus random packets, with results
// checked by a scoreboard fed from a packet-level sum model.
module tb_csa_accum_ctrl;
  localparam int N       = 8;
  localparam int MAX_OPS = 4;
  localparam int ACC_W   = 10;
  localparam int CNT_W   = 3;
  localparam int W       = 1 + CNT_W + ACC_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic [N-1:0]     in_data = '0;
  logic             out_ready = 1'b1;
  logic             in_ready;
  logic             out_valid;
  logic [ACC_W-1:0] out_result;
  logic [CNT_W-1:0] out_count;
  logic             dut_forced;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int unsigned  pkt_ops[$];
  bit rand_rdy = 1'b0;
  bit hold_rdy = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

`ifdef CSA_ACCUM_CTRL_FORCED_FLAG_EN
  logic out_forced;
  assign dut_forced = out_forced;
`else
  assign dut_forced = 1'b0;
`endif

  csa_accum_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_count  (out_count)
`ifdef CSA_ACCUM_CTRL_FORCED_FLAG_EN
    ,
    .out_forced (out_forced)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A packet closes on in_last or when it holds MAX_OPS operands; its result
  // is the plain integer sum of its operands.
  task automatic model_accept(input int unsigned d, input bit last);
    int unsigned sum;
    bit forced;
    sum = 0;
    pkt_ops.push_back(d);
    if (last || pkt_ops.size() == MAX_OPS) begin
      foreach (pkt_ops[i]) sum += pkt_ops[i];
`ifdef CSA_ACCUM_CTRL_FORCED_FLAG_EN
      forced = !last;
`else
      forced = 1'b0;
`endif
      exp_q.push_back({forced, CNT_W'(pkt_ops.size()), ACC_W'(sum)});
      pkt_ops.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic send_op(input logic [N-1:0] d, input bit last);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
      @(posedge clk);
    end else begin
      @(posedge clk);
      model_accept(int'(d), last);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout: got 0 expected 1 at %0t", $time);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic set_hold(input bit h);
    @(negedge clk);
    hold_rdy = h;
    @(posedge clk);
    #1;
  endtask

  // Consumer ready: always high, randomly toggling, or held low.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = hold_rdy ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      got = {dut_forced, out_count, out_result};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got %0d expected none", out_result);
      end else begin
        exp = exp_q.pop_front();
        check("sb_result", 32'(got[ACC_W-1:0]), 32'(exp[ACC_W-1:0]));
        check("sb_count", 32'(got[ACC_W+CNT_W-1:ACC_W]), 32'(exp[ACC_W+CNT_W-1:ACC_W]));
        check("sb_forced", 32'(got[W-1]), 32'(exp[W-1]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit done;
    logic [N-1:0] d;
    bit last;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_out_result", 32'(out_result), 0);
    check("rst_forced", 32'(dut_forced), 0);

    // Single operand: latency and in_ready low while busy.
    send_op(8'hA5, 1'b1);
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) done = 1'b1;
      else check("busy_in_ready", 32'(in_ready), 0);
    end
    check("latency_edges", n, 4);
    check("single_result", 32'(out_result), 165);
    check("single_count", 32'(out_count), 1);
    check("done_in_ready", 32'(in_ready), 0);
    wait_drain();

    // Full-width carry chain across every chunk.
    repeat (3) send_op(8'hFF, 1'b0);
    send_op(8'hFF, 1'b1);
    wait_valid();
    check("ff4_result", 32'(out_result), 1020);
    check("ff4_count", 32'(out_count), 4);
    check("ff4_forced", 32'(dut_forced), 0);
    wait_drain();

    // Forced end at MAX_OPS; the fifth operand waits for the handshake.
    set_hold(1'b1);
    send_op(8'd10, 1'b0);
    send_op(8'd20, 1'b0);
    send_op(8'd30, 1'b0);
    send_op(8'd40, 1'b0);
    wait_valid();
    check("forced_result", 32'(out_result), 100);
    check("forced_count", 32'(out_count), 4);
`ifdef CSA_ACCUM_CTRL_FORCED_FLAG_EN
    check("forced_flag", 32'(dut_forced), 1);
`endif
    in_valid = 1'b1;
    in_data  = 8'd50;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("held_off_in_ready", 32'(in_ready), 0);
    end
    hold_rdy = 1'b0;
    send_op(8'd50, 1'b0);
    send_op(8'd60, 1'b1);
    wait_valid();
    check("after_forced_result", 32'(out_result), 110);
    check("after_forced_count", 32'(out_count), 2);
    wait_drain();

    // Gaps inside a packet.
    send_op(8'd1, 1'b0);
    idle(1);
    send_op(8'd2, 1'b0);
    idle(2);
    send_op(8'd3, 1'b1);
    wait_valid();
    check("gap_result", 32'(out_result), 6);
    check("gap_count", 32'(out_count), 3);
    wait_drain();

    // Back-pressure in DONE.
    set_hold(1'b1);
    send_op(8'd5, 1'b0);
    send_op(8'd9, 1'b1);
    wait_valid();
    repeat (5) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_result", 32'(out_result), 14);
      check("stall_count", 32'(out_count), 2);
      check("stall_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    hold_rdy = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("post_hs_out_valid", 32'(out_valid), 0);
    check("post_hs_in_ready", 32'(in_ready), 1);
    check("post_hs_result_kept", 32'(out_result), 14);
    check("post_hs_count_kept", 32'(out_count), 2);
    wait_drain();

    // Reset during the second resolve cycle drops the packet.
    send_op(8'h80, 1'b0);
    send_op(8'h80, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    pkt_ops.delete();
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_out_result", 32'(out_result), 0);
    check("abort_out_count", 32'(out_count), 0);
    check("abort_in_ready", 32'(in_ready), 1);
    repeat (6) begin
      @(posedge clk);
      #1;
      check("abort_no_ghost", 32'(out_valid), 0);
    end
    send_op(8'd7, 1'b1);
    wait_valid();
    check("post_abort_result", 32'(out_result), 7);
    check("post_abort_count", 32'(out_count), 1);
    wait_drain();

    // Random packets with random gaps and random consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      last = ($urandom_range(0, 3) == 0);
      send_op(d, last);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    if (pkt_ops.size() != 0) send_op(8'($urandom_range(0, 255)), 1'b1);
    wait_drain();
    rand_rdy = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
